lcg_stream: RTL and testbench

Parametrised, sequential linear congruential generator. One start handshake latches a seed and runtime coefficients, then the block emits COUNT successive values X(n+1) = (X(n)·MULTIPLIER + INCREMENT) mod MODULUS on a valid/ready output stream. The modulo uses a bit-serial shift-subtract reducer, so any runtime modulus is supported without a hardware divider. It replaces fixed-width, three-output, single-cycle LCG blocks in the FPGA generator datapath.

---
 rtl/lcg_stream.sv | 168 ++++++++++++++++
 tb/tb_lcg_stream.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/lcg_stream.sv
// lcg_stream: sequential linear congruential generator.
// One accepted start latches seed and coefficients, then COUNT values
// X(n+1) = (X(n)*MULTIPLIER + INCREMENT) mod MODULUS are emitted on a
// valid/ready stream. The modulo is a bit-serial shift-subtract reducer,
// so any runtime modulus works without a divider.
//
// Ports:
//   CLK, RST_N             clock (rising edge), async active-low reset
//   start                  request, accepted only while idle
//   seed                   X(0), sampled on accepted start
//   MODULUS/MULTIPLIER/
//   INCREMENT              m, a, c, sampled on accepted start
//   busy                   high in every state except idle
//   out_value/out_valid/
//   out_ready              output stream
//   out_index              0-based index of the current value
//   out_last               with out_valid on the final value
//   done                   1-cycle pulse after the final handshake
//   err                    1-cycle pulse when a start with MODULUS=0 is rejected
module lcg_stream #(
   parameter int WIDTH = 32,
   parameter int COUNT = 3,
   localparam int IW = (COUNT > 1) ? $clog2(COUNT) : 1
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             start,
   input  logic [WIDTH-1:0] seed,
   input  logic [WIDTH-1:0] MODULUS,
   input  logic [WIDTH-1:0] MULTIPLIER,
   input  logic [WIDTH-1:0] INCREMENT,
   output logic             busy,
   output logic [WIDTH-1:0] out_value,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IW-1:0]    out_index,
   output logic             out_last,
   output logic             done,
   output logic             err
);

   localparam int P  = 2 * WIDTH + 1;
   localparam int BW = $clog2(P);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_RED, S_OUT} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] m_q, m_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] c_q, c_d;
   logic [WIDTH-1:0] x_q, x_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [P-1:0]     prod_q, prod_d;
   logic [WIDTH:0]   r_q, r_d;
   logic [BW-1:0]    bcnt_q, bcnt_d;
   logic [WIDTH-1:0] val_q, val_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic [WIDTH+1:0] t;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= S_IDLE;
         m_q     <= '0;
         a_q     <= '0;
         c_q     <= '0;
         x_q     <= '0;
         idx_q   <= '0;
         prod_q  <= '0;
         r_q     <= '0;
         bcnt_q  <= '0;
         val_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         a_q     <= a_d;
         c_q     <= c_d;
         x_q     <= x_d;
         idx_q   <= idx_d;
         prod_q  <= prod_d;
         r_q     <= r_d;
         bcnt_q  <= bcnt_d;
         val_q   <= val_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      a_d     = a_q;
      c_d     = c_q;
      x_d     = x_q;
      idx_d   = idx_q;
      prod_d  = prod_q;
      r_d     = r_q;
      bcnt_d  = bcnt_q;
      val_d   = val_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      t       = '0;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               if (MODULUS == '0) begin
                  err_d = 1'b1;
               end else begin
                  m_d     = MODULUS;
                  a_d     = MULTIPLIER;
                  c_d     = INCREMENT;
                  x_d     = seed;
                  idx_d   = '0;
                  state_d = S_MUL;
               end
            end
         end
         S_MUL: begin
            // Full-width product: x*a + c < 2^(2*WIDTH+1), never truncated.
            prod_d  = P'(x_q) * P'(a_q) + P'(c_q);
            r_d     = '0;
            bcnt_d  = BW'(P - 1);
            state_d = S_RED;
         end
         S_RED: begin
            // Restoring reduction: r < m holds after every step, so one
            // conditional subtract per shifted-in bit suffices.
            t = {r_q, prod_q[P-1]};
            if (t >= {2'b00, m_q}) begin
               r_d = (WIDTH + 1)'(t - {2'b00, m_q});
            end else begin
               r_d = (WIDTH + 1)'(t);
            end
            prod_d = prod_q << 1;
            bcnt_d = bcnt_q - 1'b1;
            if (bcnt_q == '0) begin
               val_d   = r_d[WIDTH-1:0];
               state_d = S_OUT;
            end
         end
         S_OUT: begin
            if (out_ready) begin
               x_d = val_q;
               if (idx_q == IW'(COUNT - 1)) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = S_MUL;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy      = (state_q != S_IDLE);
   assign out_valid = (state_q == S_OUT);
   assign out_value = val_q;
   assign out_index = idx_q;
   assign out_last  = out_valid && (idx_q == IW'(COUNT - 1));
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_lcg_stream.sv
// Directed and randomised check of lcg_stream (WIDTH=32, COUNT=3).
module tb_lcg_stream;

   localparam int W = 32;

   logic          CLK;
   logic          RST_N;
   logic          start;
   logic [W-1:0]  seed;
   logic [W-1:0]  MODULUS;
   logic [W-1:0]  MULTIPLIER;
   logic [W-1:0]  INCREMENT;
   logic          busy;
   logic [W-1:0]  out_value;
   logic          out_valid;
   logic          out_ready;
   logic [1:0]    out_index;
   logic          out_last;
   logic          done;
   logic          err;

   int total = 0;
   int bad   = 0;

   lcg_stream #(.WIDTH(W), .COUNT(3)) dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .start      (start),
      .seed       (seed),
      .MODULUS    (MODULUS),
      .MULTIPLIER (MULTIPLIER),
      .INCREMENT  (INCREMENT),
      .busy       (busy),
      .out_value  (out_value),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_index  (out_index),
      .out_last   (out_last),
      .done       (done),
      .err        (err)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [W-1:0] lcg_model(input logic [W-1:0] x, a, c, m);
      logic [2*W:0] p;
      p = {33'd0, x} * {33'd0, a} + {33'd0, c};
      return W'(p % {33'd0, m});
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_valid(output int n);
      n = 1;
      while (!out_valid && n < 300) begin
         @(posedge CLK); #1;
         n++;
      end
      chk("valid_timeout", out_valid, 1);
   endtask

   // Full sequence from start to done; stall = cycles out_ready is held low
   // on each value; meddle = change inputs and pulse start mid-sequence.
   task automatic do_seq(input logic [W-1:0] sd, m, a, c, e0, e1, e2,
                         input int stall, input bit meddle);
      logic [W-1:0] e [3];
      int n;
      e[0] = e0; e[1] = e1; e[2] = e2;
      seed = sd; MODULUS = m; MULTIPLIER = a; INCREMENT = c;
      start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      for (int i = 0; i < 3; i++) begin
         out_ready = (stall == 0);
         n = 1;
         while (!out_valid && n < 300) begin
            if (meddle && i == 1 && n == 10) begin
               seed = ~sd; MODULUS = m + 5; MULTIPLIER = a + 7; INCREMENT = c + 3;
               start = 1'b1;
            end else begin
               start = 1'b0;
            end
            @(posedge CLK); #1;
            n++;
         end
         start = 1'b0;
         chk("valid_timeout", out_valid, 1);
         chk("latency", n, 67);
         chk("value", out_value, e[i]);
         chk("index", out_index, i);
         chk("last", out_last, (i == 2));
         for (int s = 0; s < stall; s++) begin
            @(posedge CLK); #1;
            chk("stall_valid", out_valid, 1);
            chk("stall_value", out_value, e[i]);
         end
         out_ready = 1'b1;
         @(posedge CLK); #1;
         chk("valid_drop", out_valid, 0);
         chk("done", done, (i == 2));
         if (i == 2) chk("busy_at_done", busy, 0);
      end
      out_ready = 1'b0;
      @(posedge CLK); #1;
      chk("done_one_cycle", done, 0);
   endtask

   initial begin
      logic [W-1:0] rs, rm, ra, rc, r0, r1, r2;
      int n;

      RST_N = 1'b0; start = 1'b0; out_ready = 1'b0;
      seed = '0; MODULUS = '0; MULTIPLIER = '0; INCREMENT = '0;
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_value", out_value, 0);
      chk("rst_index", out_index, 0);
      chk("rst_last", out_last, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      RST_N = 1'b1;
      @(posedge CLK); #1;

      // Hand-computed reference sequence, free-flowing consumer.
      do_seq(32'd96, 32'd993441, 32'd4001, 32'd60211,
             32'd444307, 32'd466569, 32'd127141, 0, 1'b0);

      // Same with 10 stall cycles per value.
      do_seq(32'd96, 32'd993441, 32'd4001, 32'd60211,
             32'd444307, 32'd466569, 32'd127141, 10, 1'b0);

      // Zero modulus is rejected.
      seed = 32'd5; MODULUS = '0; MULTIPLIER = 32'd3; INCREMENT = 32'd1;
      start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
      chk("err_pulse", err, 1);
      chk("err_busy", busy, 0);
      chk("err_valid", out_valid, 0);
      @(posedge CLK); #1;
      chk("err_one_cycle", err, 0);
      chk("err_busy_after", busy, 0);
      do_seq(32'd96, 32'd993441, 32'd4001, 32'd60211,
             32'd444307, 32'd466569, 32'd127141, 0, 1'b0);

      // Input changes and a start pulse while busy are ignored.
      do_seq(32'd96, 32'd993441, 32'd4001, 32'd60211,
             32'd444307, 32'd466569, 32'd127141, 0, 1'b1);
      chk("meddle_idle", busy, 0);

      // Reset during reduction of the second value.
      seed = 32'd96; MODULUS = 32'd993441; MULTIPLIER = 32'd4001; INCREMENT = 32'd60211;
      start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
      wait_valid(n);
      chk("rst_seq_v0", out_value, 32'd444307);
      out_ready = 1'b1;
      @(posedge CLK); #1;
      out_ready = 1'b0;
      repeat (20) @(posedge CLK);
      #2;
      chk("rst_seq_busy_before", busy, 1);
      RST_N = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_valid", out_valid, 0);
      chk("arst_value", out_value, 0);
      chk("arst_index", out_index, 0);
      chk("arst_last", out_last, 0);
      chk("arst_done", done, 0);
      chk("arst_err", err, 0);
      @(posedge CLK); #1;
      RST_N = 1'b1;
      @(posedge CLK); #1;
      chk("arst_no_done", done, 0);
      do_seq(32'd96, 32'd993441, 32'd4001, 32'd60211,
             32'd444307, 32'd466569, 32'd127141, 0, 1'b0);

      // m = 1 gives zeros.
      do_seq(32'd12345, 32'd1, 32'd777, 32'd99, 32'd0, 32'd0, 32'd0, 0, 1'b0);

      // All-ones corner: (m*m + m) mod m = 0, then c mod m = 0.
      chk("model_all_ones", lcg_model('1, '1, '1, '1), 0);
      do_seq('1, '1, '1, '1, 32'd0, 32'd0, 32'd0, 0, 1'b0);

      // Random regression against the arithmetic model.
      for (int k = 0; k < 100; k++) begin
         rs = $urandom;
         ra = $urandom;
         rc = $urandom;
         rm = (k % 2 == 0) ? $urandom : $urandom_range(1, 1000);
         if (rm == '0) rm = 32'd7;
         r0 = lcg_model(rs, ra, rc, rm);
         r1 = lcg_model(r0, ra, rc, rm);
         r2 = lcg_model(r1, ra, rc, rm);
         do_seq(rs, rm, ra, rc, r0, r1, r2, (k % 7 == 0) ? 3 : 0, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
